lstm_cell_pipe: RTL and testbench

- Parametrised, handshaked LSTM cell-update pipeline, successor to the single-node LSTM datapath.
- Time-multiplexes NUM_CELLS cells through one datapath and keeps each cell's C(t-1) in an internal state array.
- Takes four gate pre-activations per cell (i, c~, f, o), sits between the gate-MAC array and the recurrent/output buffers, and returns c_t and h_t per cell.

---
 rtl/lstm_pkg.sv | 49 ++++
 rtl/lstm_hard_act.sv | 29 ++
 rtl/lstm_cell_pipe.sv | 147 ++++++++++++++
 tb/tb_lstm_cell_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared fixed-point constants, beat/result types and saturating arithmetic
// helpers for the LSTM cell-update pipeline.
package lstm_pkg;

    localparam int LSTM_XLEN = 16;
    localparam int LSTM_FRAC = 8;
    localparam int LSTM_IDW  = 5;

    typedef enum logic {
        ACT_SIG  = 1'b0,
        ACT_TANH = 1'b1
    } lstm_act_e;

    typedef struct packed {
        logic [LSTM_IDW-1:0]  id;
        logic                 seq_start;
        logic [LSTM_XLEN-1:0] pre_i;
        logic [LSTM_XLEN-1:0] pre_c;
        logic [LSTM_XLEN-1:0] pre_f;
        logic [LSTM_XLEN-1:0] pre_o;
    } lstm_gate_beat_t;

    typedef struct packed {
        logic [LSTM_IDW-1:0]  id;
        logic [LSTM_XLEN-1:0] c;
        logic [LSTM_XLEN-1:0] h;
    } lstm_cell_result_t;

    // Clamp v into the signed range of a w-bit word (w <= 32).
    function automatic logic signed [63:0] fx_sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Full-precision product, floor shift by frac, then saturate to w bits.
    function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int frac, input int w);
        logic signed [63:0] p;
        p = (a * b) >>> frac;
        return fx_sat(p, w);
    endfunction

endpackage

// File: rtl/lstm_hard_act.sv
// Piecewise-linear activation: hard sigmoid clamp(x/4 + 0.5, 0, 1) or
// hard tanh clamp(x, -1, 1), chosen by MODE.
module lstm_hard_act
    import lstm_pkg::*;
#(
    parameter int        XLEN = LSTM_XLEN,
    parameter int        FRAC = LSTM_FRAC,
    parameter lstm_act_e MODE = ACT_SIG
) (
    input  logic [XLEN-1:0] x,
    output logic [XLEN-1:0] y
);

    localparam int ONE = 1 << FRAC;
    localparam int LO  = (MODE == ACT_SIG) ? 0 : -ONE;

    logic signed [XLEN:0] xs;
    logic signed [XLEN:0] t;

    always_comb begin
        xs = $signed({x[XLEN-1], x});
        if (MODE == ACT_SIG) t = (xs >>> 2) + (XLEN+1)'(ONE / 2);
        else                 t = xs;
        if (int'(t) > ONE)     y = XLEN'(ONE);
        else if (int'(t) < LO) y = XLEN'(LO);
        else                   y = t[XLEN-1:0];
    end

endmodule

// File: rtl/lstm_cell_pipe.sv
// Four-stage handshaked LSTM cell-update pipeline with per-cell C(t-1) storage.
// Define LSTM_CELL_BYPASS_EN to forward S1's Ct to the accept read and drop the same-cell stall.
module lstm_cell_pipe
    import lstm_pkg::*;
#(
    parameter int XLEN      = LSTM_XLEN,
    parameter int FRAC      = LSTM_FRAC,
    parameter int NUM_CELLS = 32,
    parameter int IDW       = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IDW-1:0]  in_cell_id,
    input  logic            in_seq_start,
    input  logic [XLEN-1:0] in_pre_i,
    input  logic [XLEN-1:0] in_pre_c,
    input  logic [XLEN-1:0] in_pre_f,
    input  logic [XLEN-1:0] in_pre_o,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDW-1:0]  out_cell_id,
    output logic [XLEN-1:0] out_c,
    output logic [XLEN-1:0] out_h
);

    typedef logic signed [XLEN-1:0] word_t;

    function automatic word_t mul_x(input word_t a, input word_t b);
        return word_t'(fx_mul(64'(a), 64'(b), FRAC, XLEN));
    endfunction

    function automatic word_t add_sat(input word_t a, input word_t b);
        return word_t'(fx_sat(64'(a) + 64'(b), XLEN));
    endfunction

    function automatic logic id_ok(input logic [IDW-1:0] id);
        return 32'(id) < NUM_CELLS;
    endfunction

    word_t act_i, act_c, act_f, act_o, tanh_ct;
    word_t cprev_a, ct_s1;
    logic  adv, hit_p1, hazard, accept;

    logic           vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
    logic           vld_p3_d, vld_p3_q, vld_p4_d, vld_p4_q;
    logic [IDW-1:0] id_p1_d, id_p1_q, id_p2_d, id_p2_q;
    logic [IDW-1:0] id_p3_d, id_p3_q, id_p4_d, id_p4_q;
    word_t          i_p1_d, i_p1_q, g_p1_d, g_p1_q, f_p1_d, f_p1_q;
    word_t          o_p1_d, o_p1_q, cprev_p1_d, cprev_p1_q;
    word_t          ct_p2_d, ct_p2_q, o_p2_d, o_p2_q;
    word_t          th_p3_d, th_p3_q, o_p3_d, o_p3_q, ct_p3_d, ct_p3_q;
    word_t          h_p4_d, h_p4_q, ct_p4_d, ct_p4_q;
    word_t          state_d [NUM_CELLS];
    word_t          state_q [NUM_CELLS];

    lstm_hard_act #(.XLEN(XLEN), .FRAC(FRAC), .MODE(ACT_SIG))  u_act_i  (.x(in_pre_i), .y(act_i));
    lstm_hard_act #(.XLEN(XLEN), .FRAC(FRAC), .MODE(ACT_TANH)) u_act_c  (.x(in_pre_c), .y(act_c));
    lstm_hard_act #(.XLEN(XLEN), .FRAC(FRAC), .MODE(ACT_SIG))  u_act_f  (.x(in_pre_f), .y(act_f));
    lstm_hard_act #(.XLEN(XLEN), .FRAC(FRAC), .MODE(ACT_SIG))  u_act_o  (.x(in_pre_o), .y(act_o));
    lstm_hard_act #(.XLEN(XLEN), .FRAC(FRAC), .MODE(ACT_TANH)) u_act_ct (.x(ct_p2_q),  .y(tanh_ct));

    // Accept stage: handshake, hazard and C(t-1) lookup
    always_comb begin
        adv    = !vld_p4_q || out_ready;
        hit_p1 = vld_p1_q && (id_p1_q == in_cell_id);
`ifdef LSTM_CELL_BYPASS_EN
        hazard = 1'b0;
`else
        hazard = hit_p1;
`endif
        in_ready = adv && !hazard;
        accept   = in_valid && in_ready;
        ct_s1    = add_sat(mul_x(f_p1_q, cprev_p1_q), mul_x(i_p1_q, g_p1_q));
        cprev_a  = '0;
        if (!in_seq_start && id_ok(in_cell_id)) begin
            cprev_a = state_q[in_cell_id];
`ifdef LSTM_CELL_BYPASS_EN
            if (hit_p1) cprev_a = ct_s1;
`endif
        end
    end

    // S1 -> S4 advance together; the state write rides the S1 -> S2 edge
    always_comb begin
        vld_p1_d = vld_p1_q;  id_p1_d = id_p1_q;  i_p1_d = i_p1_q;  g_p1_d = g_p1_q;
        f_p1_d   = f_p1_q;    o_p1_d  = o_p1_q;   cprev_p1_d = cprev_p1_q;
        vld_p2_d = vld_p2_q;  id_p2_d = id_p2_q;  ct_p2_d = ct_p2_q;  o_p2_d = o_p2_q;
        vld_p3_d = vld_p3_q;  id_p3_d = id_p3_q;  th_p3_d = th_p3_q;
        o_p3_d   = o_p3_q;    ct_p3_d = ct_p3_q;
        vld_p4_d = vld_p4_q;  id_p4_d = id_p4_q;  h_p4_d = h_p4_q;  ct_p4_d = ct_p4_q;
        if (adv) begin
            vld_p1_d = accept;    id_p1_d = in_cell_id;  i_p1_d = act_i;  g_p1_d = act_c;
            f_p1_d   = act_f;     o_p1_d  = act_o;       cprev_p1_d = cprev_a;
            vld_p2_d = vld_p1_q;  id_p2_d = id_p1_q;     ct_p2_d = ct_s1;  o_p2_d = o_p1_q;
            vld_p3_d = vld_p2_q;  id_p3_d = id_p2_q;     th_p3_d = tanh_ct;
            o_p3_d   = o_p2_q;    ct_p3_d = ct_p2_q;
            vld_p4_d = vld_p3_q;  id_p4_d = id_p3_q;
            h_p4_d   = mul_x(o_p3_q, th_p3_q);
            ct_p4_d  = ct_p3_q;
        end
        state_d = state_q;
        if (adv && vld_p1_q && id_ok(id_p1_q)) state_d[id_p1_q] = ct_s1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            vld_p4_q <= 1'b0;
            id_p4_q  <= '0;
            h_p4_q   <= '0;
            ct_p4_q  <= '0;
            for (int k = 0; k < NUM_CELLS; k++) state_q[k] <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            vld_p4_q <= vld_p4_d;
            id_p4_q  <= id_p4_d;
            h_p4_q   <= h_p4_d;
            ct_p4_q  <= ct_p4_d;
            state_q  <= state_d;
        end
        id_p1_q    <= id_p1_d;
        i_p1_q     <= i_p1_d;
        g_p1_q     <= g_p1_d;
        f_p1_q     <= f_p1_d;
        o_p1_q     <= o_p1_d;
        cprev_p1_q <= cprev_p1_d;
        id_p2_q    <= id_p2_d;
        ct_p2_q    <= ct_p2_d;
        o_p2_q     <= o_p2_d;
        id_p3_q    <= id_p3_d;
        th_p3_q    <= th_p3_d;
        o_p3_q     <= o_p3_d;
        ct_p3_q    <= ct_p3_d;
    end

    assign out_valid   = vld_p4_q;
    assign out_cell_id = id_p4_q;
    assign out_c       = ct_p4_q;
    assign out_h       = h_p4_q;

endmodule

// File: tb/tb_lstm_cell_pipe.sv
// Bench for lstm_cell_pipe: directed and randomized beats checked against a
// sequential behavioural model of the cell recurrence.
module tb_lstm_cell_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_cell_id = '0;
    logic        in_seq_start = 1'b0;
    logic [15:0] in_pre_i = '0, in_pre_c = '0, in_pre_f = '0, in_pre_o = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_cell_id;
    logic [15:0] out_c, out_h;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int mst [32];
    int exp_c[$], exp_h[$], exp_id[$];
    int got_c[$], got_h[$], got_id[$], got_cyc[$];

    always #5 clock = ~clock;

    lstm_cell_pipe dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_cell_id(in_cell_id),
        .in_seq_start(in_seq_start),
        .in_pre_i(in_pre_i), .in_pre_c(in_pre_c), .in_pre_f(in_pre_f), .in_pre_o(in_pre_o),
        .out_valid(out_valid), .out_ready(out_ready), .out_cell_id(out_cell_id),
        .out_c(out_c), .out_h(out_h)
    );

    // Reference arithmetic, Q8.8 as plain integers
    function automatic int sat16(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int fmul(int a, int b);
        longint p;
        p = longint'(a) * longint'(b);
        return sat16(p >>> 8);
    endfunction

    function automatic int hsig(int x);
        int t;
        t = (x >>> 2) + 128;
        return (t < 0) ? 0 : ((t > 256) ? 256 : t);
    endfunction

    function automatic int htanh(int x);
        return (x < -256) ? -256 : ((x > 256) ? 256 : x);
    endfunction

    task automatic clr_q();
        exp_c.delete(); exp_h.delete(); exp_id.delete();
        got_c.delete(); got_h.delete(); got_id.delete(); got_cyc.delete();
    endtask

    // One clock: drive inputs, update model on acceptance, capture output transfers.
    task automatic step(input logic v, input int id, input logic seq,
                        input int pi, input int pc, input int pf, input int po,
                        input logic ordy, output logic acc);
        int cp, ct;
        @(negedge clock);
        in_valid = v; in_cell_id = 5'(id); in_seq_start = seq;
        in_pre_i = 16'(pi); in_pre_c = 16'(pc); in_pre_f = 16'(pf); in_pre_o = 16'(po);
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            cp = seq ? 0 : mst[id];
            ct = sat16(longint'(fmul(hsig(pf), cp)) + longint'(fmul(hsig(pi), htanh(pc))));
            mst[id] = ct;
            exp_c.push_back(ct);
            exp_h.push_back(fmul(hsig(po), htanh(ct)));
            exp_id.push_back(id);
        end
        if (out_valid && ordy) begin
            got_c.push_back(int'($signed(out_c)));
            got_h.push_back(int'($signed(out_h)));
            got_id.push_back(int'(out_cell_id));
            got_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, 0, 1'b0, 0, 0, 0, 0, ordy, a);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (got_c.size() < exp_c.size() && n < 60) begin
            idle(1'b1);
            n++;
        end
        repeat (3) idle(1'b1);
        n_total++;
        if (got_c.size() != exp_c.size())
            $display("FAIL %s_drain results got=%0d want=%0d", tag, got_c.size(), exp_c.size());
        else n_pass++;
    endtask

    task automatic send(input int id, input logic seq, input int pi, input int pc,
                        input int pf, input int po, inout int stalls);
        logic a;
        a = 1'b0;
        for (int n = 0; n < 8 && !a; n++) begin
            step(1'b1, id, seq, pi, pc, pf, po, 1'b1, a);
            if (!a) stalls++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
        n_total++; if (out_c !== 16'd0) $display("FAIL reset_out_c got=%0d want=0", out_c); else n_pass++;
        n_total++; if (out_h !== 16'd0) $display("FAIL reset_out_h got=%0d want=0", out_h); else n_pass++;
        n_total++; if (out_cell_id !== 5'd0) $display("FAIL reset_out_id got=%0d want=0", out_cell_id); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        logic a0, a1, a2;
        int t0;
        clr_q();
        t0 = cyc;
        step(1'b1, 3, 1'b1, 0, 256, 0, 0, 1'b1, a0);
        step(1'b1, 5, 1'b1, 0, 256, 0, 0, 1'b1, a1);
        idle(1'b1);
        step(1'b1, 3, 1'b0, 0, 256, 0, 0, 1'b1, a2);
        drain("basic");
        n_total++; if (!(a0 && a1 && a2)) $display("FAIL basic_accept got=%b%b%b want=111", a0, a1, a2); else n_pass++;
        n_total++;
        if (got_c[0] !== 128 || got_h[0] !== 64 || got_id[0] !== 3)
            $display("FAIL basic_first got c=%0d h=%0d id=%0d want c=128 h=64 id=3", got_c[0], got_h[0], got_id[0]);
        else n_pass++;
        n_total++;
        if (got_c[1] !== 128 || got_h[1] !== 64 || got_id[1] !== 5)
            $display("FAIL basic_other_cell got c=%0d h=%0d id=%0d want c=128 h=64 id=5", got_c[1], got_h[1], got_id[1]);
        else n_pass++;
        n_total++;
        if (got_c[2] !== 192 || got_h[2] !== 96 || got_id[2] !== 3)
            $display("FAIL basic_recur got c=%0d h=%0d id=%0d want c=192 h=96 id=3", got_c[2], got_h[2], got_id[2]);
        else n_pass++;
        n_total++;
        if (got_cyc[0] - t0 !== 4) $display("FAIL basic_latency got=%0d want=4", got_cyc[0] - t0); else n_pass++;
    endtask

    task automatic test_hazard();
        int stalls, want;
        stalls = 0;
`ifdef LSTM_CELL_BYPASS_EN
        want = 0;
`else
        want = 1;
`endif
        clr_q();
        send(7, 1'b1, 0, 256, 0, 0, stalls);
        send(7, 1'b0, 0, 256, 0, 0, stalls);
        drain("hazard");
        n_total++; if (stalls !== want) $display("FAIL hazard_stalls got=%0d want=%0d", stalls, want); else n_pass++;
        n_total++;
        if (got_c[0] !== 128 || got_id[0] !== 7) $display("FAIL hazard_first got c=%0d id=%0d want c=128 id=7", got_c[0], got_id[0]);
        else n_pass++;
        n_total++;
        if (got_c[1] !== 192 || got_h[1] !== 96 || got_id[1] !== 7)
            $display("FAIL hazard_second got c=%0d h=%0d id=%0d want c=192 h=96 id=7", got_c[1], got_h[1], got_id[1]);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int stalls, want;
        stalls = 0;
        clr_q();
        for (int b = 0; b < 200; b++) send(0, (b == 0), 4096, 4096, 4096, 4096, stalls);
        drain("sat");
        for (int k = 0; k < 200; k++) begin
            want = (256 * (k + 1) > 32767) ? 32767 : 256 * (k + 1);
            n_total++;
            if (got_c[k] !== want || got_h[k] !== 256 || got_id[k] !== 0)
                $display("FAIL sat_beat%0d got c=%0d h=%0d id=%0d want c=%0d h=256 id=0", k, got_c[k], got_h[k], got_id[k], want);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int bi[6], bc[6], bf[6], bo[6], snap[6];
        int idx, stalls;
        logic a;
        idx = 0; stalls = 0;
        clr_q();
        for (int k = 0; k < 6; k++) begin
            bi[k] = int'($urandom_range(0, 2048)) - 1024;
            bc[k] = int'($urandom_range(0, 2048)) - 1024;
            bf[k] = int'($urandom_range(0, 2048)) - 1024;
            bo[k] = int'($urandom_range(0, 2048)) - 1024;
        end
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 8 + idx, 1'b0, bi[idx], bc[idx], bf[idx], bo[idx], 1'b0, a);
            if (a) idx++;
        end
        n_total++; if (idx > 4) $display("FAIL bp_accepted_during_stall got=%0d want<=4", idx); else n_pass++;
        for (int n = 0; n < 20 && idx < 6; n++) begin
            step(1'b1, 8 + idx, 1'b0, bi[idx], bc[idx], bf[idx], bo[idx], 1'b1, a);
            if (a) idx++;
        end
        drain("bp");
        n_total++; if (got_c.size() !== 6) $display("FAIL bp_count got=%0d want=6", got_c.size()); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_total++;
            if (got_c[k] !== exp_c[k] || got_h[k] !== exp_h[k] || got_id[k] !== exp_id[k])
                $display("FAIL bp_beat%0d got c=%0d h=%0d id=%0d want c=%0d h=%0d id=%0d",
                         k, got_c[k], got_h[k], got_id[k], exp_c[k], exp_h[k], exp_id[k]);
            else n_pass++;
        end
        // Follow-up read: i=0, f=1.0 makes Ct equal the stored C(t-1)
        for (int k = 0; k < 6; k++) snap[k] = mst[8 + k];
        clr_q();
        for (int k = 0; k < 6; k++) send(8 + k, 1'b0, -4096, 0, 4096, 4096, stalls);
        drain("bp_read");
        for (int k = 0; k < 6; k++) begin
            n_total++;
            if (got_c[k] !== snap[k] || got_id[k] !== 8 + k)
                $display("FAIL bp_readback%0d got c=%0d id=%0d want c=%0d id=%0d", k, got_c[k], got_id[k], snap[k], 8 + k);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int id, pi, pc, pf, po, sent;
        logic seq, v, ordy, a, need;
        sent = 0; need = 1'b1;
        id = 0; seq = 1'b0; pi = 0; pc = 0; pf = 0; po = 0;
        clr_q();
        for (int n = 0; n < 600 && sent < 80; n++) begin
            if (need) begin
                id  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
                seq = ($urandom_range(0, 7) == 0);
                pi  = int'($urandom_range(0, 65535)) - 32768;
                pc  = int'($urandom_range(0, 65535)) - 32768;
                pf  = int'($urandom_range(0, 65535)) - 32768;
                po  = int'($urandom_range(0, 65535)) - 32768;
                need = 1'b0;
            end
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            step(v, id, seq, pi, pc, pf, po, ordy, a);
            if (a) begin sent++; need = 1'b1; end
        end
        drain("rand");
        n_total++; if (got_c.size() !== 80) $display("FAIL rand_count got=%0d want=80", got_c.size()); else n_pass++;
        for (int k = 0; k < exp_c.size(); k++) begin
            n_total++;
            if (got_c[k] !== exp_c[k] || got_h[k] !== exp_h[k] || got_id[k] !== exp_id[k])
                $display("FAIL rand_beat%0d got c=%0d h=%0d id=%0d want c=%0d h=%0d id=%0d",
                         k, got_c[k], got_h[k], got_id[k], exp_c[k], exp_h[k], exp_id[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        logic a;
        int stalls;
        stalls = 0;
        clr_q();
        step(1'b1, 3, 1'b1, 0, 256, 0, 0, 1'b1, a);
        step(1'b1, 4, 1'b1, 0, 256, 0, 0, 1'b1, a);
        step(1'b1, 5, 1'b1, 0, 256, 0, 0, 1'b1, a);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid got=%b want=0", out_valid); else n_pass++;
        foreach (mst[k]) mst[k] = 0;
        clr_q();
        send(3, 1'b0, 0, 256, 0, 0, stalls);
        drain("midreset");
        n_total++;
        if (got_c.size() !== 1) $display("FAIL midreset_count got=%0d want=1", got_c.size()); else n_pass++;
        n_total++;
        if (got_c[0] !== 128 || got_h[0] !== 64 || got_id[0] !== 3)
            $display("FAIL midreset_cprev got c=%0d h=%0d id=%0d want c=128 h=64 id=3", got_c[0], got_h[0], got_id[0]);
        else n_pass++;
    endtask

    initial begin
        foreach (mst[k]) mst[k] = 0;
        test_reset();
        test_basic();
        test_hazard();
        test_saturation();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
